noc_router_port: RTL and testbench

Router-side input port for the 8-bit flit NoC: it accepts the flit stream that a network interface transmits and buffers it in an input FIFO. It decodes the header destination and forwards each packet wormhole-style to one of four output links. Each packet holds the route from header to tail. It is the receiving end of the NI-to-router link and sits at each router input.

---
 rtl/noc_router_port.sv | 114 +++++++++++
 tb/tb_noc_router_port.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/noc_router_port.sv
// noc_router_port: NI-to-router input port with a show-ahead FIFO and wormhole forwarding to four links.
// Defining NOC_HDR_CHECK_EN adds the header prefix check, the DROP state and pkt_err.
module noc_router_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_flit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_flit,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic       out_last,
  output logic       pkt_err,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef NOC_HDR_CHECK_EN
  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FWD} state_t;
`endif
  state_t state_q, state_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [1:0] dest_q, dest_d;
  logic [2:0] cnt_q, cnt_d;
  logic empty, full, push, pop, tail, hdr_ok;
  logic [7:0] head;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    head = mem_q[rd_q[AW-1:0]];
    // index 1 is always data, index 5 always the tail
    tail = (cnt_q == 3'd5) || (cnt_q >= 3'd2 && head == 8'hFF);
`ifdef NOC_HDR_CHECK_EN
    hdr_ok = head[7:2] == 6'b101111;
`else
    hdr_ok = 1'b1;
`endif
    in_ready = !full;
    push = in_valid && !full;
    out_flit = empty ? 8'h00 : head;
    out_valid = '0;
    out_last = 1'b0;
    pkt_err = 1'b0;
    pop = 1'b0;
    state_d = state_q;
    dest_d = dest_q;
    cnt_d = cnt_q;
    if (!empty) begin
      case (state_q)
        IDLE: begin
          if (hdr_ok) begin
            out_valid[head[1:0]] = 1'b1;
            if (out_ready[head[1:0]]) begin
              pop = 1'b1;
              dest_d = head[1:0];
              cnt_d = 3'd1;
              state_d = FWD;
            end
          end
`ifdef NOC_HDR_CHECK_EN
          else begin
            pkt_err = 1'b1;
            pop = 1'b1;
            cnt_d = 3'd1;
            state_d = DROP;
          end
`endif
        end
        FWD: begin
          out_valid[dest_q] = 1'b1;
          out_last = tail;
          if (out_ready[dest_q]) begin
            pop = 1'b1;
            cnt_d = tail ? 3'd0 : 3'(cnt_q + 3'd1);
            state_d = tail ? IDLE : FWD;
          end
        end
`ifdef NOC_HDR_CHECK_EN
        DROP: begin
          pop = 1'b1;
          cnt_d = tail ? 3'd0 : 3'(cnt_q + 3'd1);
          state_d = tail ? IDLE : DROP;
        end
`endif
        default: ;
      endcase
    end
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    busy = (state_q != IDLE) || !empty;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      dest_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      dest_q <= dest_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= in_flit;
  end
endmodule

// File: tb/tb_noc_router_port.sv
// tb_noc_router_port: directed and random packets checked against a packet-level scoreboard.
module tb_noc_router_port;
  logic clk = 1'b0, rst;
  logic [7:0] in_flit, out_flit;
  logic in_valid, in_ready, out_last, pkt_err, busy;
  logic [3:0] out_valid, out_ready, fixed_rdy, rnd_val;
  logic rnd_rdy = 1'b0;
  int tests = 0, fails = 0, cyc = 0, errs_seen = 0, exp_errs = 0, p0;
  typedef struct {logic [1:0] link; logic [7:0] flit; logic last;} ent_t;
  ent_t exp_q[$];
  int hs_cyc[$];
  logic [3:0] prev_v = '0;
  logic [7:0] prev_f = '0;
  logic prev_hs = 1'b0, m_hs;
  int m_l;
  ent_t m_e;

  noc_router_port #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .pkt_err(pkt_err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_val <= 4'($urandom);
  assign out_ready = rnd_rdy ? rnd_val : fixed_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_hs = |(out_valid & out_ready);
      chk("onehot", 32'($countones(out_valid) <= 1), 1);
      if (out_valid == 4'b0) chk("last_without_valid", out_last, 0);
      if (prev_v != 4'b0 && !prev_hs) begin
        chk("hold_valid", out_valid, prev_v);
        chk("hold_flit", out_flit, prev_f);
      end
      if (pkt_err) errs_seen++;
      if (m_hs) begin
        m_l = 0;
        for (int i = 0; i < 4; i++) if (out_valid[i]) m_l = i;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("extra_flit", exp_q.size(), 1);
        else begin
          m_e = exp_q.pop_front();
          chk("link", m_l, m_e.link);
          chk("flit", out_flit, m_e.flit);
          chk("last", out_last, m_e.last);
        end
      end
      prev_v = out_valid;
      prev_f = out_flit;
      prev_hs = m_hs;
    end else prev_v = '0;
  end

  task automatic model(input logic [7:0] p[$]);
    logic bad = 1'b0;
    logic [7:0] h = p[0];
`ifdef NOC_HDR_CHECK_EN
    bad = h[7:2] != 6'b101111;
`endif
    if (bad) exp_errs++;
    else for (int i = 0; i < p.size(); i++) exp_q.push_back('{h[1:0], p[i], i == p.size() - 1});
  endtask

  task automatic send(input logic [7:0] f);
    int w = 0;
    in_flit = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin w++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pkt(input logic [7:0] p[$], input bit gaps = 0);
    model(p);
    foreach (p[i]) begin
      send(p[i]);
      if (gaps && $urandom_range(3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 300) begin @(posedge clk); #1; w++; end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic rand_pkt();
    logic [7:0] p[$];
    logic [7:0] b = 8'($urandom);
    int n = $urandom_range(1, 5);
    if ($urandom_range(7) == 0) begin
      if (b[7:2] == 6'b101111) b[7] = 1'b0;
    end else b = {6'b101111, 2'($urandom)};
    p.push_back(b);
    for (int i = 1; i <= n; i++) begin
      b = 8'($urandom);
      if (i >= 2 && i <= 4 && b == 8'hFF) b = 8'h00;
      p.push_back(b);
    end
    if (n < 5) p.push_back(8'hFF);
    pkt(p, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = 8'h00; fixed_rdy = 4'hF;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    hs_cyc.delete();
    p0 = cyc;
    pkt('{8'hBD, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF});
    drain();
    chk("full_hs_count", hs_cyc.size(), 6);
    for (int i = 0; i < 6 && i < hs_cyc.size(); i++) chk("full_hs_cycle", hs_cyc[i], p0 + 1 + i);
    pkt('{8'hBC, 8'hFF, 8'hAA, 8'hFF});
    drain();
    pkt('{8'hBF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    pkt('{8'hBC, 8'h5A, 8'hFF});
    drain();
    fixed_rdy = 4'b1011;
    model('{8'hBE, 8'h11, 8'h22, 8'h33, 8'hFF});
    send(8'hBE); send(8'h11); send(8'h22); send(8'h33);
    in_flit = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_full", in_ready, 0);
    @(negedge clk);
    chk("bp_still_full", in_ready, 0);
    chk("bp_busy", busy, 1);
    fixed_rdy = 4'hF;
    send(8'hFF);
    drain();
    pkt('{8'h3F, 8'h11, 8'hFF});
    pkt('{8'hBC, 8'hAA, 8'hFF});
    drain();
    chk("pkt_err_count", errs_seen, exp_errs);
    fixed_rdy = 4'h0;
    send(8'hBD); send(8'h12);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pkt_err", pkt_err, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_out_valid", out_valid, 0);
    @(posedge clk); #1 fixed_rdy = 4'hF;
    pkt('{8'hBE, 8'h33, 8'hFF});
    drain();
    rnd_rdy = 1'b1;
    repeat (60) rand_pkt();
    drain();
    rnd_rdy = 1'b0;
    chk("pkt_err_total", errs_seen, exp_errs);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
